cpu_regbank: RTL and testbench
==============================

// Module: cpu_regbank
// PURPOSE
//  Architectural register file for the MCS8 pipeline: registers A,B,C,D,E,H,L (index 0..6).
//  Owns the write-back (W) stage commit: selects the W result by destination class (C/S/E/M)
//  and writes it on the clock edge.
//  Supplies the committed register values (REG_BANK_I) that the cpu_forward instances override
//  with in-flight E/M/W results.
//  Index 7 (M, memory via HL) is not stored here; it is addressed through HL_ADDR_O.
// PARAMETERS
//  DW      8   data width of each register
//  AW      3   register index width
//  RST_VAL 0   reset value of every stored register
// PORTS
//  CLK_I          in   1   clock, rising edge
//  RSTN_I         in   1   asynchronous active-low reset
//  W_DST_I        in   3   W-stage destination register index
//  W_VALID_I      in   1   W-stage instruction valid (not a bubble)
//  W_DSTR_CS_I    in   1   W-stage instruction writes a register
//  W_DSTR_CS_C_I  in   1   result class C (constant/immediate) -> W_VAL_C_I
//  W_DSTR_CS_S_I  in   1   result class S (source register move) -> W_VAL_S_I
//  W_DSTR_CS_E_I  in   1   result class E (ALU result) -> W_VAL_E_I
//  W_DSTR_CS_M_I  in   1   result class M (memory load) -> W_VAL_M_I
//  W_VAL_C_I      in   8   class C result
//  W_VAL_S_I      in   8   class S result
//  W_VAL_E_I      in   8   class E result
//  W_VAL_M_I      in   8   class M result
//  W_STALL_I      in   1   W stage held by pipeline control; commit inhibited
//  RD0_SRC_I      in   3   read port 0 index
//  RD0_BANK_O     out  8   read port 0 data (to cpu_forward REG_BANK_I)
//  RD1_SRC_I      in   3   read port 1 index
//  RD1_BANK_O     out  8   read port 1 data (to cpu_forward REG_BANK_I)
//  HL_ADDR_O      out  14  memory address {H[5:0],L} for M-operand accesses
//  WB_ERR_O       out  1   sticky: illegal write-back class select detected
// BEHAVIOUR
//  - Reset (RSTN_I=0, async): all 7 registers = RST_VAL; WB_ERR_O=0; hence RDx_BANK_O=0
//    and HL_ADDR_O=0. Reset asserted mid-write aborts the write.
//  - Commit: wr_en = W_VALID_I & W_DSTR_CS_I & ~W_STALL_I & (W_DST_I!=7) & onehot(C,S,E,M).
//    On the rising edge with wr_en=1: reg[W_DST_I] <= selected W_VAL_x_I. One write per cycle.
//  - Class select must be one-hot when W_VALID_I & W_DSTR_CS_I.
//    If zero or >1 class bits are set: no write, and WB_ERR_O<=1 on that edge (held until reset).
//  - W_STALL_I=1: no write; the same W instruction commits exactly once when the stall drops.
//  - W_DST_I=7 (M): no register write and no error (memory store path handles it).
//  - Reads: combinational from the array, zero latency. Index 7 reads 8'h00.
//    Both ports may address the same or different registers freely.
//  - Read during write, same index: the port returns the OLD value (pre-edge).
//    cpu_forward W-override supplies the new one. Exception: see CONFIGURATION.
//  - HL_ADDR_O = {reg[5][5:0], reg[6]}; updates the cycle after an H or L write.
//  - Widths: no arithmetic; all values pass through unmodified.
// CONFIGURATION
//  CPU_REGBANK_BYPASS_EN defined:
//    - When wr_en=1 and RDx_SRC_I==W_DST_I, RDx_BANK_O returns the value being written
//      (write-through), combinationally in the same cycle.
//    - HL_ADDR_O is likewise bypassed for H/L writes.
//    - Lets a build omit the W-stage cpu_forward override.
//  CPU_REGBANK_BYPASS_EN undefined: old-value read as above; HL_ADDR_O reflects only
//    committed state.
// STRUCTURE
//  - Shared package/header cpu_defs: register index constants REG_A=0..REG_L=6, REG_M=7;
//    DW/AW widths; class-select bit positions C,S,E,M.
//  - Sub-module cpu_wb_select: combinational one-hot class mux; outputs wb_data[7:0],
//    sel_ok, sel_err. Also reusable by the W-stage forward path.
//  - Top holds the register array, the sticky error flop, the read muxes and optional bypass.
// TESTING
//  1 Reset: RSTN_I=0 async mid-cycle -> RD0/RD1=8'h00, HL_ADDR_O=0, WB_ERR_O=0 immediately.
//  2 Write/read: W_DST=1, CS=1, CS_E=1, VAL_E=8'h5A, VALID=1 -> next cycle RD0_SRC=1 reads 8'h5A;
//    RD1_SRC=2 reads 8'h00.
//  3 Stall: W_STALL_I=1 for 3 cycles with write to A (CS_M, VAL_M=8'hC3) -> A unchanged;
//    stall drops -> A=8'hC3 after exactly one commit.
//  4 Bad select: CS_C=CS_E=1, W_DST=4 -> reg E unchanged, WB_ERR_O=1 next cycle and stays 1
//    through later legal writes.
//  5 HL/M: write H=8'hFF then L=8'h12 -> HL_ADDR_O=14'h3F12; write W_DST=7 -> no change,
//    no error; RD0_SRC=7 -> 8'h00.
//  6 Same-cycle read of D during write D=8'h77 (old 8'h10):
//    bypass off -> 8'h10; CPU_REGBANK_BYPASS_EN -> 8'h77.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared MCS8 definitions: data/index widths, register indices A..L and M,
// and the bit positions of the write-back class-select vector.
package cpu_defs;

  localparam int CPU_DW   = 8;
  localparam int CPU_AW   = 3;
  localparam int NUM_REGS = 7;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_H = 3'd5;
  localparam logic [2:0] REG_L = 3'd6;
  localparam logic [2:0] REG_M = 3'd7;

  // Bit positions inside the 4-bit class-select vector {M,E,S,C}
  localparam int CS_C = 0;
  localparam int CS_S = 1;
  localparam int CS_E = 2;
  localparam int CS_M = 3;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/cpu_wb_select.sv
// Combinational one-hot write-back class mux (C/S/E/M). Shared by the register
// bank commit and the W-stage forward path.
module cpu_wb_select
  import cpu_defs::*;
#(
  parameter int DW = CPU_DW
) (
  input  logic [3:0]    sel,
  input  logic [DW-1:0] val_c,
  input  logic [DW-1:0] val_s,
  input  logic [DW-1:0] val_e,
  input  logic [DW-1:0] val_m,
  output logic [DW-1:0] wb_data,
  output logic          sel_ok,
  output logic          sel_err
);

  always_comb begin
    sel_ok  = is_onehot4(sel);
    sel_err = ~sel_ok;
    wb_data = '0;
    // Illegal selects yield zero so a bad encoding never leaks a stray value
    if (sel_ok) begin
      if (sel[CS_C])      wb_data = val_c;
      else if (sel[CS_S]) wb_data = val_s;
      else if (sel[CS_E]) wb_data = val_e;
      else                wb_data = val_m;
    end
  end

endmodule

// File: rtl/cpu_regbank.sv
// MCS8 architectural register file (A..L) with W-stage commit, two combinational
// read ports and the HL memory address. Optional write-through: CPU_REGBANK_BYPASS_EN.
module cpu_regbank
  import cpu_defs::*;
#(
  parameter int            DW      = CPU_DW,
  parameter int            AW      = CPU_AW,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic            CLK_I,
  input  logic            RSTN_I,
  input  logic [AW-1:0]   W_DST_I,
  input  logic            W_VALID_I,
  input  logic            W_DSTR_CS_I,
  input  logic            W_DSTR_CS_C_I,
  input  logic            W_DSTR_CS_S_I,
  input  logic            W_DSTR_CS_E_I,
  input  logic            W_DSTR_CS_M_I,
  input  logic [DW-1:0]   W_VAL_C_I,
  input  logic [DW-1:0]   W_VAL_S_I,
  input  logic [DW-1:0]   W_VAL_E_I,
  input  logic [DW-1:0]   W_VAL_M_I,
  input  logic            W_STALL_I,
  input  logic [AW-1:0]   RD0_SRC_I,
  output logic [DW-1:0]   RD0_BANK_O,
  input  logic [AW-1:0]   RD1_SRC_I,
  output logic [DW-1:0]   RD1_BANK_O,
  output logic [2*DW-3:0] HL_ADDR_O,
  output logic            WB_ERR_O
);

  logic [DW-1:0] regs [NUM_REGS];
  logic [3:0]    cs_sel;
  logic [DW-1:0] wb_data;
  logic          sel_ok;
  logic          sel_err;
  logic          wr_req;
  logic          wr_en;
  logic          err_set;
  logic [DW-1:0] rd0_arr;
  logic [DW-1:0] rd1_arr;
  logic [DW-1:0] h_val;
  logic [DW-1:0] l_val;

  always_comb begin
    cs_sel       = '0;
    cs_sel[CS_C] = W_DSTR_CS_C_I;
    cs_sel[CS_S] = W_DSTR_CS_S_I;
    cs_sel[CS_E] = W_DSTR_CS_E_I;
    cs_sel[CS_M] = W_DSTR_CS_M_I;
  end

  cpu_wb_select #(.DW(DW)) u_wb_select (
    .sel     (cs_sel),
    .val_c   (W_VAL_C_I),
    .val_s   (W_VAL_S_I),
    .val_e   (W_VAL_E_I),
    .val_m   (W_VAL_M_I),
    .wb_data (wb_data),
    .sel_ok  (sel_ok),
    .sel_err (sel_err)
  );

  // A bad class select is flagged even while stalled; M destinations go to the store path
  assign wr_req  = W_VALID_I & W_DSTR_CS_I;
  assign wr_en   = wr_req & ~W_STALL_I & (W_DST_I != AW'(REG_M)) & sel_ok;
  assign err_set = wr_req & sel_err;

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (W_DST_I == AW'(i)) regs[i] <= wb_data;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)      WB_ERR_O <= 1'b0;
    else if (err_set) WB_ERR_O <= 1'b1;
  end

  // Index 7 matches no entry and therefore reads as zero
  always_comb begin
    rd0_arr = '0;
    rd1_arr = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RD0_SRC_I == AW'(i)) rd0_arr = regs[i];
      if (RD1_SRC_I == AW'(i)) rd1_arr = regs[i];
    end
  end

`ifdef CPU_REGBANK_BYPASS_EN
  always_comb begin
    RD0_BANK_O = (wr_en && RD0_SRC_I == W_DST_I) ? wb_data : rd0_arr;
    RD1_BANK_O = (wr_en && RD1_SRC_I == W_DST_I) ? wb_data : rd1_arr;
    h_val      = (wr_en && W_DST_I == AW'(REG_H)) ? wb_data : regs[REG_H];
    l_val      = (wr_en && W_DST_I == AW'(REG_L)) ? wb_data : regs[REG_L];
  end
`else
  always_comb begin
    RD0_BANK_O = rd0_arr;
    RD1_BANK_O = rd1_arr;
    h_val      = regs[REG_H];
    l_val      = regs[REG_L];
  end
`endif

  assign HL_ADDR_O = {h_val[DW-3:0], l_val};

endmodule

// File: tb/tb_cpu_regbank.sv
// Bench for cpu_regbank: vector table with scoreboard queue, then hand-written
// stall, read-during-write, bad-select and reset sequences.
module tb_cpu_regbank;

  localparam int W = 31;
`ifdef CPU_REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  w_dst;
  logic        w_valid, w_dcs, cs_c, cs_s, cs_e, cs_m, w_stall;
  logic [7:0]  val_c, val_s, val_e, val_m;
  logic [2:0]  rd0_src, rd1_src;
  logic [7:0]  rd0, rd1;
  logic [13:0] hl;
  logic        err;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  typedef struct {
    logic [2:0]  dst;
    logic        valid;
    logic        dcs;
    logic [3:0]  csel;
    logic [7:0]  vc, vs, ve, vm;
    logic [2:0]  rs0, rs1;
    logic [7:0]  e_rd0, e_rd1;
    logic [13:0] e_hl;
    logic        e_err;
  } vec_t;

  vec_t vecs[10];

  cpu_regbank dut (
    .CLK_I(clk), .RSTN_I(rst_n), .W_DST_I(w_dst), .W_VALID_I(w_valid),
    .W_DSTR_CS_I(w_dcs), .W_DSTR_CS_C_I(cs_c), .W_DSTR_CS_S_I(cs_s),
    .W_DSTR_CS_E_I(cs_e), .W_DSTR_CS_M_I(cs_m),
    .W_VAL_C_I(val_c), .W_VAL_S_I(val_s), .W_VAL_E_I(val_e), .W_VAL_M_I(val_m),
    .W_STALL_I(w_stall), .RD0_SRC_I(rd0_src), .RD0_BANK_O(rd0),
    .RD1_SRC_I(rd1_src), .RD1_BANK_O(rd1), .HL_ADDR_O(hl), .WB_ERR_O(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive_idle();
    w_valid = 1'b0; w_dcs = 1'b0; w_stall = 1'b0;
    {cs_m, cs_e, cs_s, cs_c} = 4'b0000;
  endtask

  // Selected class carries val, the others carry ~val so a wrong mux shows up
  task automatic drive_wr(input logic [2:0] dst, input logic [3:0] csel, input logic [7:0] val);
    w_dst = dst; w_valid = 1'b1; w_dcs = 1'b1;
    {cs_m, cs_e, cs_s, cs_c} = csel;
    val_c = csel[0] ? val : ~val;
    val_s = csel[1] ? val : ~val;
    val_e = csel[2] ? val : ~val;
    val_m = csel[3] ? val : ~val;
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] exp_w;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    w_dst = 3'd0; val_c = 8'h00; val_s = 8'h00; val_e = 8'h00; val_m = 8'h00;
    rd0_src = 3'd0; rd1_src = 3'd0;
    drive_idle();

    //             dst   v  cs csel     C      S      E      M     rs0   rs1   rd0    rd1    hl        err
    vecs[0] = '{3'd1, 1, 1, 4'b0100, 8'h01, 8'h02, 8'h5A, 8'h04, 3'd1, 3'd2, 8'h5A, 8'h00, 14'h0000, 0};
    vecs[1] = '{3'd0, 1, 1, 4'b0001, 8'h3C, 8'h81, 8'h82, 8'h83, 3'd0, 3'd1, 8'h3C, 8'h5A, 14'h0000, 0};
    vecs[2] = '{3'd2, 1, 1, 4'b0010, 8'h90, 8'hA5, 8'h91, 8'h92, 3'd2, 3'd0, 8'hA5, 8'h3C, 14'h0000, 0};
    vecs[3] = '{3'd3, 1, 1, 4'b1000, 8'h20, 8'h21, 8'h22, 8'h10, 3'd3, 3'd3, 8'h10, 8'h10, 14'h0000, 0};
    vecs[4] = '{3'd5, 1, 1, 4'b0100, 8'h00, 8'h01, 8'hFF, 8'h02, 3'd5, 3'd7, 8'hFF, 8'h00, 14'h3F00, 0};
    vecs[5] = '{3'd6, 1, 1, 4'b0001, 8'h12, 8'h34, 8'h56, 8'h78, 3'd6, 3'd5, 8'h12, 8'hFF, 14'h3F12, 0};
    vecs[6] = '{3'd7, 1, 1, 4'b0100, 8'h98, 8'h97, 8'h99, 8'h96, 3'd7, 3'd6, 8'h00, 8'h12, 14'h3F12, 0};
    vecs[7] = '{3'd4, 0, 1, 4'b0001, 8'hEE, 8'hED, 8'hEC, 8'hEB, 3'd4, 3'd1, 8'h00, 8'h5A, 14'h3F12, 0};
    vecs[8] = '{3'd4, 1, 0, 4'b0001, 8'hEE, 8'hED, 8'hEC, 8'hEB, 3'd4, 3'd2, 8'h00, 8'hA5, 14'h3F12, 0};
    vecs[9] = '{3'd4, 1, 1, 4'b0100, 8'h40, 8'h41, 8'h44, 8'h43, 3'd4, 3'd0, 8'h44, 8'h3C, 14'h3F12, 0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd1_src = 3'd6;
    #1;
    check("reset_rd0", 32'(rd0), 32'h00);
    check("reset_rd1", 32'(rd1), 32'h00);
    check("reset_hl", 32'(hl), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      w_dst = vecs[i].dst; w_valid = vecs[i].valid; w_dcs = vecs[i].dcs;
      {cs_m, cs_e, cs_s, cs_c} = vecs[i].csel;
      val_c = vecs[i].vc; val_s = vecs[i].vs; val_e = vecs[i].ve; val_m = vecs[i].vm;
      rd0_src = vecs[i].rs0; rd1_src = vecs[i].rs1;
      exp_q.push_back({vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_hl, vecs[i].e_err});
      @(posedge clk);
      #1 drive_idle();
      #1;
      got = {rd0, rd1, hl, err};
      exp_w = exp_q.pop_front();
      check($sformatf("vec%0d_rd0", i), 32'(got[30:23]), 32'(exp_w[30:23]));
      check($sformatf("vec%0d_rd1", i), 32'(got[22:15]), 32'(exp_w[22:15]));
      check($sformatf("vec%0d_hl", i), 32'(got[14:1]), 32'(exp_w[14:1]));
      check($sformatf("vec%0d_err", i), 32'(got[0]), 32'(exp_w[0]));
    end

    // Stall: A held at 3C for three stalled edges, then a single commit of C3
    @(negedge clk);
    drive_wr(3'd0, 4'b1000, 8'hC3);
    w_stall = 1'b1;
    rd0_src = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold%0d", c), 32'(rd0), 32'h3C);
    end
    @(negedge clk);
    w_stall = 1'b0;
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("stall_commit", 32'(rd0), 32'hC3);
    check("stall_err", 32'(err), 32'h0);

    // Same-cycle read of D (old 10) while writing 77
    @(negedge clk);
    drive_wr(3'd3, 4'b0001, 8'h77);
    rd0_src = 3'd3; rd1_src = 3'd3;
    #1;
    check("rdw_rd0", 32'(rd0), BYPASS ? 32'h77 : 32'h10);
    check("rdw_rd1", 32'(rd1), BYPASS ? 32'h77 : 32'h10);
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("rdw_after", 32'(rd0), 32'h77);

    // HL address while writing L=34
    @(negedge clk);
    drive_wr(3'd6, 4'b0100, 8'h34);
    #1;
    check("hl_during", 32'(hl), BYPASS ? 32'h3F34 : 32'h3F12);
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("hl_after", 32'(hl), 32'h3F34);

    // Bad select C+E to E: no write, sticky error
    @(negedge clk);
    drive_wr(3'd4, 4'b0101, 8'hBB);
    rd0_src = 3'd4;
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("badsel_e", 32'(rd0), 32'h44);
    check("badsel_err", 32'(err), 32'h1);
    @(negedge clk);
    drive_wr(3'd4, 4'b0100, 8'h55);
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("badsel_legal_e", 32'(rd0), 32'h55);
    check("badsel_sticky", 32'(err), 32'h1);

    // Async reset mid-cycle during a pending write to A
    @(negedge clk);
    drive_wr(3'd0, 4'b0001, 8'hAB);
    rd0_src = 3'd0; rd1_src = 3'd6;
    #2 rst_n = 1'b0;
    #1;
    check("areset_rd0", 32'(rd0), 32'h00);
    check("areset_rd1", 32'(rd1), 32'h00);
    check("areset_hl", 32'(hl), 32'h0);
    check("areset_err", 32'(err), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("areset_abort", 32'(rd0), 32'h00);

    // Zero class bits: no write to C, error set
    @(negedge clk);
    drive_wr(3'd2, 4'b0000, 8'h66);
    rd0_src = 3'd2;
    @(posedge clk);
    #1 drive_idle();
    #1;
    check("zerosel_c", 32'(rd0), 32'h00);
    check("zerosel_err", 32'(err), 32'h1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
